// File: rtl/lcd_pkg.sv
// Shared types, colour constants and default panel timing for the LCD window driver.
package lcd_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t BLACK = 16'h0000;
  localparam rgb565_t RED   = 16'hF800;
  localparam rgb565_t BLUE  = 16'h001F;

  // Width of the pixel counters and of the signed window arithmetic.
  localparam int unsigned CW = 10;

  localparam int unsigned DEF_CLK_DIV = 4;
  localparam int unsigned DEF_H_SYNC  = 30;
  localparam int unsigned DEF_H_BP    = 37;
  localparam int unsigned DEF_H_ACT   = 320;
  localparam int unsigned DEF_H_FP    = 21;
  localparam int unsigned DEF_V_SYNC  = 3;
  localparam int unsigned DEF_V_BP    = 15;
  localparam int unsigned DEF_V_ACT   = 240;
  localparam int unsigned DEF_V_FP    = 4;

  function automatic int unsigned tot4(input int unsigned s, input int unsigned bp,
                                       input int unsigned act, input int unsigned fp);
    return s + bp + act + fp;
  endfunction

  localparam int unsigned DEF_H_TOT = tot4(DEF_H_SYNC, DEF_H_BP, DEF_H_ACT, DEF_H_FP);
  localparam int unsigned DEF_V_TOT = tot4(DEF_V_SYNC, DEF_V_BP, DEF_V_ACT, DEF_V_FP);

endpackage

// File: rtl/lcd_window_driver_timing.sv
// Pixel-clock prescaler, x/y raster counters and sync/active decode.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned H_ACT   = DEF_H_ACT,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP,
  parameter int unsigned V_ACT   = DEF_V_ACT,
  parameter int unsigned V_FP    = DEF_V_FP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 pix_tick,
  output logic                 lcd_clk,
  output logic [CW-1:0]        x,
  output logic [CW-1:0]        y,
  output logic                 hs_a,
  output logic                 vs_a,
  output logic                 act,
  output logic signed [CW-1:0] ax,
  output logic signed [CW-1:0] ay
);

  localparam int unsigned H_TOT = tot4(H_SYNC, H_BP, H_ACT, H_FP);
  localparam int unsigned V_TOT = tot4(V_SYNC, V_BP, V_ACT, V_FP);
  localparam int unsigned DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] X_MAX    = CW'(H_TOT - 1);
  localparam logic [CW-1:0] Y_MAX    = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_SYNC_W = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_W = CW'(V_SYNC);

  localparam logic signed [CW-1:0] H_OFS   = CW'(H_SYNC + H_BP);
  localparam logic signed [CW-1:0] V_OFS   = CW'(V_SYNC + V_BP);
  localparam logic signed [CW-1:0] H_ACT_S = CW'(H_ACT);
  localparam logic signed [CW-1:0] V_ACT_S = CW'(V_ACT);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] x_q, y_q;

  assign div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
  assign pix_tick  = (div_cnt_q == DIV_HALF - 1'b1);

  // lcd_clk is registered from the next count so the pin is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      lcd_clk   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      lcd_clk   <= (div_cnt_d >= DIV_HALF);
      if (pix_tick) begin
        if (x_q == X_MAX) begin
          x_q <= '0;
          y_q <= (y_q == Y_MAX) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign hs_a = (x_q < H_SYNC_W);
  assign vs_a = (y_q < V_SYNC_W);
  assign ax   = $signed(x_q) - H_OFS;
  assign ay   = $signed(y_q) - V_OFS;
  assign act  = !ax[CW-1] && (ax < H_ACT_S) && !ay[CW-1] && (ay < V_ACT_S);

endmodule

// File: rtl/lcd_window_driver.sv
// RGB565 panel driver: frame latch, per-line bitmap row fetch and registered pin stage.
module lcd_window_driver
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACT    = DEF_H_ACT,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACT    = DEF_V_ACT,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned WIN_W    = 32,
  parameter int unsigned WIN_H    = 64,
  parameter int unsigned AW       = $clog2(WIN_H),
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_en,
  input  logic [8:0]       win_x,
  input  logic [8:0]       win_y,
  input  logic [15:0]      fg_rgb,
  input  logic [15:0]      bg_rgb,
  input  logic [WIN_W-1:0] ram_db,
  output logic [AW-1:0]    ram_ab,
  output logic             ram_rd,
  output logic             lcd_clk,
  output logic             lcd_en,
  output logic             lcd_hsy,
  output logic             lcd_vsy,
  output logic [4:0]       lcd_db_r,
  output logic [5:0]       lcd_db_g,
  output logic [4:0]       lcd_db_b,
  output logic             frame_start
);

  localparam int unsigned CIW = (WIN_W > 1) ? $clog2(WIN_W) : 1;

  localparam logic [CW-1:0]        ROWBUF_X = CW'(H_SYNC + H_BP - 1);
  localparam logic signed [CW-1:0] V_ACT_S  = CW'(V_ACT);
  localparam logic signed [CW-1:0] WIN_W_S  = CW'(WIN_W);
  localparam logic signed [CW-1:0] WIN_H_S  = CW'(WIN_H);

  logic                 pix_tick, hs_a, vs_a, act;
  logic [CW-1:0]        x, y;
  logic signed [CW-1:0] ax, ay, r, c;
  logic                 line_act, row_hit, col_hit;
  logic [CIW-1:0]       c_idx;

  lcd_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .H_ACT   (H_ACT),
    .H_FP    (H_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .V_ACT   (V_ACT),
    .V_FP    (V_FP)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick),
    .lcd_clk  (lcd_clk),
    .x        (x),
    .y        (y),
    .hs_a     (hs_a),
    .vs_a     (vs_a),
    .act      (act),
    .ax       (ax),
    .ay       (ay)
  );

  logic             disp_en_l;
  logic [8:0]       win_x_l, win_y_l;
  rgb565_t          fg_l, bg_l, rgb_q;
  logic             row_valid_q, ram_rd_q, frame_start_q;
  logic [AW-1:0]    ram_ab_q;
  logic [WIN_W-1:0] row_buf_q;
  logic             hsy_q, vsy_q, en_q;

  // Negative differences fail the range checks through their sign bit.
  assign r        = ay - $signed({1'b0, win_y_l});
  assign c        = ax - $signed({1'b0, win_x_l});
  assign line_act = !ay[CW-1] && (ay < V_ACT_S);
  assign row_hit  = line_act && !r[CW-1] && (r < WIN_H_S);
  assign col_hit  = act && row_valid_q && !c[CW-1] && (c < WIN_W_S);
  assign c_idx    = c[CIW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_en_l     <= 1'b0;
      win_x_l       <= '0;
      win_y_l       <= '0;
      fg_l          <= BLACK;
      bg_l          <= BLACK;
      row_valid_q   <= 1'b0;
      ram_ab_q      <= '0;
      ram_rd_q      <= 1'b0;
      frame_start_q <= 1'b0;
      row_buf_q     <= '0;
      hsy_q         <= !SYNC_POL;
      vsy_q         <= !SYNC_POL;
      en_q          <= 1'b0;
      rgb_q         <= BLACK;
    end else begin
      frame_start_q <= 1'b0;
      ram_rd_q      <= 1'b0;
      if (pix_tick) begin
        if (x == '0 && y == '0) begin
          disp_en_l     <= disp_en;
          win_x_l       <= win_x;
          win_y_l       <= win_y;
          fg_l          <= fg_rgb;
          bg_l          <= bg_rgb;
          frame_start_q <= 1'b1;
        end
        if (x == '0) begin
          row_valid_q <= row_hit;
          ram_ab_q    <= row_hit ? r[AW-1:0] : '0;
          ram_rd_q    <= row_hit;
        end
        // Capture the row just before the first active pixel so RAM can change afterwards.
        if (x == ROWBUF_X) row_buf_q <= ram_db;
        hsy_q <= hs_a ? SYNC_POL : !SYNC_POL;
        vsy_q <= vs_a ? SYNC_POL : !SYNC_POL;
        en_q  <= act && disp_en_l;
        if (col_hit && disp_en_l) rgb_q <= row_buf_q[c_idx] ? fg_l : bg_l;
        else                      rgb_q <= BLACK;
      end
    end
  end

  assign ram_ab      = ram_ab_q;
  assign ram_rd      = ram_rd_q;
  assign frame_start = frame_start_q;
  assign lcd_hsy     = hsy_q;
  assign lcd_vsy     = vsy_q;
  assign lcd_en      = en_q;
  assign lcd_db_r    = rgb_q.r;
  assign lcd_db_g    = rgb_q.g;
  assign lcd_db_b    = rgb_q.b;

endmodule

// File: tb/tb_lcd_window_driver.sv
// Scoreboard bench for lcd_window_driver on a shrunken raster so several frames run quickly.
module tb_lcd_window_driver;
  import lcd_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned H_SYNC = 3, H_BP = 4, H_ACT = 40, H_FP = 3;
  localparam int unsigned V_SYNC = 2, V_BP = 3, V_ACT = 12, V_FP = 2;
  localparam int unsigned WIN_W = 8, WIN_H = 4, AW = 2;
  localparam bit          SYNC_POL = 1'b0;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FRAME_CLKS = H_TOT * V_TOT * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             disp_en;
  logic [8:0]       win_x, win_y;
  logic [15:0]      fg_rgb, bg_rgb;
  logic [WIN_W-1:0] ram_db;
  logic [AW-1:0]    ram_ab;
  logic             ram_rd, lcd_clk, lcd_en, lcd_hsy, lcd_vsy, frame_start;
  logic [4:0]       lcd_db_r, lcd_db_b;
  logic [5:0]       lcd_db_g;

  logic [WIN_W-1:0] mem [WIN_H];
  assign ram_db = mem[ram_ab];

  always #5 clk = ~clk;

  lcd_window_driver #(
    .CLK_DIV (CLK_DIV), .H_SYNC (H_SYNC), .H_BP (H_BP), .H_ACT (H_ACT), .H_FP (H_FP),
    .V_SYNC (V_SYNC), .V_BP (V_BP), .V_ACT (V_ACT), .V_FP (V_FP),
    .WIN_W (WIN_W), .WIN_H (WIN_H), .AW (AW), .SYNC_POL (SYNC_POL)
  ) dut (
    .clk (clk), .rst_n (rst_n), .disp_en (disp_en), .win_x (win_x), .win_y (win_y),
    .fg_rgb (fg_rgb), .bg_rgb (bg_rgb), .ram_db (ram_db), .ram_ab (ram_ab), .ram_rd (ram_rd),
    .lcd_clk (lcd_clk), .lcd_en (lcd_en), .lcd_hsy (lcd_hsy), .lcd_vsy (lcd_vsy),
    .lcd_db_r (lcd_db_r), .lcd_db_g (lcd_db_g), .lcd_db_b (lcd_db_b),
    .frame_start (frame_start)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic ck, input logic hs, input logic vs,
                                       input logic en, input logic [15:0] col, input logic fs,
                                       input logic rd, input logic [AW-1:0] ab);
    return 64'({ck, hs, vs, en, col, fs, rd, ab});
  endfunction

  function automatic logic [63:0] pins();
    return pack(lcd_clk, lcd_hsy, lcd_vsy, lcd_en, {lcd_db_r, lcd_db_g, lcd_db_b},
                frame_start, ram_rd, ram_ab);
  endfunction

  // Reference model state
  int          mdiv, mx, my, m_row;
  logic        m_en, m_rowv;
  logic [8:0]  m_wx, m_wy;
  logic [15:0] m_fg, m_bg;
  logic [AW-1:0] m_ab;
  logic [63:0] sb_q[$];
  string       tag_q[$];
  int          n_en, n_rd, n_fs, n_clkh;

  task automatic model_reset();
    mdiv = 0; mx = 0; my = 0; m_row = 0;
    m_en = 0; m_rowv = 0; m_wx = 0; m_wy = 0; m_fg = 0; m_bg = 0; m_ab = 0;
    sb_q.delete(); tag_q.delete();
  endtask

  task automatic model_tick();
    int ax, ay, r, c;
    logic hsy_e, vsy_e, en_e, fs_e, rd_e, act_e;
    logic [15:0] col;
    fs_e = 0; rd_e = 0;
    if (mx == 0 && my == 0) begin
      m_en = disp_en; m_wx = win_x; m_wy = win_y; m_fg = fg_rgb; m_bg = bg_rgb; fs_e = 1;
    end
    ax = mx - int'(H_SYNC + H_BP);
    ay = my - int'(V_SYNC + V_BP);
    if (mx == 0) begin
      r = ay - int'(m_wy);
      m_rowv = (ay >= 0) && (ay < int'(V_ACT)) && (r >= 0) && (r < int'(WIN_H));
      m_row  = m_rowv ? r : 0;
      m_ab   = AW'(m_row);
      rd_e   = m_rowv;
    end
    act_e = (ax >= 0) && (ax < int'(H_ACT)) && (ay >= 0) && (ay < int'(V_ACT));
    c     = ax - int'(m_wx);
    col   = 16'h0000;
    if (act_e && m_rowv && c >= 0 && c < int'(WIN_W)) col = mem[m_row][c] ? m_fg : m_bg;
    if (!m_en) col = 16'h0000;
    en_e  = act_e && m_en;
    hsy_e = (mx < int'(H_SYNC)) ? SYNC_POL : !SYNC_POL;
    vsy_e = (my < int'(V_SYNC)) ? SYNC_POL : !SYNC_POL;
    sb_q.push_back(pack(1'b1, hsy_e, vsy_e, en_e, col, fs_e, rd_e, m_ab));
    tag_q.push_back($sformatf("pix(%0d,%0d)", mx, my));
    mx++;
    if (mx == H_TOT) begin
      mx = 0;
      my = (my == V_TOT - 1) ? 0 : my + 1;
    end
  endtask

  task automatic step();
    logic tick;
    @(posedge clk);
    tick = (mdiv == int'(CLK_DIV / 2) - 1);
    mdiv = (mdiv == int'(CLK_DIV) - 1) ? 0 : mdiv + 1;
    if (tick) model_tick();
    #1;
    if (tick) begin
      check_eq(tag_q.pop_front(), pins(), sb_q.pop_front());
      n_en += int'(lcd_en);
    end
    n_rd   += int'(ram_rd);
    n_fs   += int'(frame_start);
    n_clkh += int'(lcd_clk);
  endtask

  // One full frame from a frame boundary; optionally retarget the window mid-frame.
  task automatic run_frame(input string tag, input int change_at);
    int exp_rd;
    n_en = 0; n_rd = 0; n_fs = 0; n_clkh = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step();
      if (i == change_at) begin
        win_x = 9'd0; win_y = 9'd0; fg_rgb = 16'h07E0; bg_rgb = 16'h1234;
      end
    end
    exp_rd = 0;
    for (int k = 0; k < int'(WIN_H); k++) if (int'(m_wy) + k < int'(V_ACT)) exp_rd++;
    check_eq({tag, ".rd_cnt"}, 64'(n_rd), 64'(exp_rd));
    check_eq({tag, ".fs_cnt"}, 64'(n_fs), 64'd1);
    check_eq({tag, ".en_cnt"}, 64'(n_en), m_en ? 64'(H_ACT * V_ACT) : 64'd0);
    check_eq({tag, ".clk_hi"}, 64'(n_clkh), 64'(FRAME_CLKS / 2));
  endtask

  task automatic reset_check(input string tag);
    check_eq(tag, pins(), pack(1'b0, !SYNC_POL, !SYNC_POL, 1'b0, 16'h0, 1'b0, 1'b0, '0));
  endtask

  initial begin
    rst_n = 1'b0;
    disp_en = 1'b1; win_x = 9'd5; win_y = 9'd2; fg_rgb = RED; bg_rgb = BLUE;
    mem[0] = 8'h01; mem[1] = 8'hA5; mem[2] = 8'h80; mem[3] = 8'h3C;
    model_reset();
    #23;
    reset_check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("win5_2", -1);

    // Window hanging off the right and bottom edges
    win_x = 9'd36; win_y = 9'd10;
    run_frame("clip", -1);

    // Mid-frame change must wait for the next frame
    win_x = 9'd20; win_y = 9'd4;
    run_frame("pre_change", FRAME_CLKS / 2);
    run_frame("post_change", -1);

    // Asynchronous reset in the middle of a line, then a blanked frame
    for (int i = 0; i < 3 * H_TOT * int'(CLK_DIV) + 37; i++) step();
    #2 rst_n = 1'b0;
    #1 reset_check("midreset");
    disp_en = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_check("midreset_hold");
    rst_n = 1'b1;
    run_frame("blank", -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
